// File: rtl/cp0_excpt_if.sv
// cp0_excpt_if: bundle between the execute stage / exception controller and
// the CP0 exception source.
//   slave  modport: the CP0 block (takes pipeline inputs, drives excptype/epc/etc.)
//   master modport: pipeline + controller side (drives the inputs, observes outputs)
// Signals:
//   instValid, pc, sysCall, eret  execute-stage instruction information
//   cp0we, cp0waddr, cp0wdata     MTC0 write port
//   cp0raddr, cp0rdata            MFC0 read port
//   excpt                         controller commit strobe
//   excptype, epc, timerInt       exception class, saved PC, timer pending flag
interface cp0_excpt_if;
    logic        instValid;
    logic [31:0] pc;
    logic        sysCall;
    logic        eret;
    logic        cp0we;
    logic [4:0]  cp0waddr;
    logic [31:0] cp0wdata;
    logic [4:0]  cp0raddr;
    logic [31:0] cp0rdata;
    logic        excpt;
    logic [31:0] excptype;
    logic [31:0] epc;
    logic        timerInt;

    modport slave (
        input  instValid, pc, sysCall, eret, cp0we, cp0waddr, cp0wdata, cp0raddr, excpt,
        output cp0rdata, excptype, epc, timerInt
    );

    modport master (
        output instValid, pc, sysCall, eret, cp0we, cp0waddr, cp0wdata, cp0raddr, excpt,
        input  cp0rdata, excptype, epc, timerInt
    );
endinterface

// File: rtl/cp0_excpt.sv
// cp0_excpt: coprocessor-0 exception source.
// Holds Count, Compare, Status, Cause and EPC, raises the timer interrupt, classifies
// the execute-stage instruction into excptype and commits exception entry/return on
// the controller's excpt strobe.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  synchronous active-high reset
//   bus  cp0_excpt_if slave modport (pipeline inputs, MTC0/MFC0, excpt, outputs)
module cp0_excpt #(
    parameter logic [31:0] TIMER_CODE   = 32'h0000_0004,
    parameter logic [31:0] SYSCALL_CODE = 32'h0000_0100,
    parameter logic [31:0] ERET_CODE    = 32'h0000_0200
) (
    input logic           clk,
    input logic           rst,
    cp0_excpt_if.slave    bus
);

    localparam logic       RstEnable   = 1'b1;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] epc_q, epc_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic        im7_q, im7_d;
    logic        ip7_q, ip7_d;
    logic [4:0]  exccode_q, exccode_d;

    logic [31:0] status_word;
    logic [31:0] cause_word;
    logic        mtc0_ok;
    logic        timer_match;

    assign status_word = {16'b0, im7_q, 13'b0, exl_q, ie_q};
    assign cause_word  = {16'b0, ip7_q, 8'b0, exccode_q, 2'b0};

    // The instruction being squashed by an exception must not update CP0 state.
    assign mtc0_ok     = bus.cp0we & ~bus.excpt;
    assign timer_match = (count_q == compare_q) && (compare_q != 32'd0);

    always_comb begin
        bus.excptype = 32'd0;
        if (bus.instValid) begin
            if (ip7_q & im7_q & ie_q & ~exl_q) begin
                bus.excptype = TIMER_CODE;
            end else if (bus.sysCall) begin
                bus.excptype = SYSCALL_CODE;
            end else if (bus.eret) begin
                bus.excptype = ERET_CODE;
            end
        end
    end

    always_comb begin
        bus.cp0rdata = 32'd0;
        case (bus.cp0raddr)
            RegCount:   bus.cp0rdata = count_q;
            RegCompare: bus.cp0rdata = compare_q;
            RegStatus:  bus.cp0rdata = status_word;
            RegCause:   bus.cp0rdata = cause_word;
            RegEpc:     bus.cp0rdata = epc_q;
            default:    bus.cp0rdata = 32'd0;
        endcase
    end

    assign bus.epc      = epc_q;
    assign bus.timerInt = ip7_q;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        epc_d     = epc_q;
        ie_d      = ie_q;
        exl_d     = exl_q;
        im7_d     = im7_q;
        exccode_d = exccode_q;
        ip7_d     = ip7_q | timer_match;

        if (mtc0_ok) begin
            case (bus.cp0waddr)
                RegCount: count_d = bus.cp0wdata;
                RegCompare: begin
                    compare_d = bus.cp0wdata;
                    ip7_d     = 1'b0;  // acknowledge beats a same-cycle match
                end
                RegStatus: begin
                    ie_d  = bus.cp0wdata[0];
                    exl_d = bus.cp0wdata[1];
                    im7_d = bus.cp0wdata[15];
                end
                RegEpc:  epc_d = bus.cp0wdata;
                default: ;
            endcase
        end

        // A commit with excptype == 0 falls through to default: nothing changes.
        if (bus.excpt) begin
            case (bus.excptype)
                TIMER_CODE: begin
                    epc_d     = bus.pc;
                    exl_d     = 1'b1;
                    exccode_d = 5'd0;
                end
                SYSCALL_CODE: begin
                    epc_d     = bus.pc + 32'd4;
                    exl_d     = 1'b1;
                    exccode_d = 5'd8;
                end
                ERET_CODE: exl_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            epc_q     <= 32'd0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            im7_q     <= 1'b0;
            ip7_q     <= 1'b0;
            exccode_q <= 5'd0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            epc_q     <= epc_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            im7_q     <= im7_d;
            ip7_q     <= ip7_d;
            exccode_q <= exccode_d;
        end
    end

endmodule
